// File: rtl/div_ratio_ctrl_if.sv
// Configuration handshake between a requester and the clock-ratio controller.
interface div_ratio_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_half, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/div_ratio_ctrl.sv
// Programmable 50%-duty clock divider whose half-period can be changed on the fly
// without ever emitting a phase shorter than the old or new half-period.
module div_ratio_ctrl #(
  parameter int WIDTH        = 32,
  parameter int DEFAULT_HALF = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  div_ratio_ctrl_if.slave  cfg,
  output logic             div_clk,
  output logic             rise_tick,
  output logic [WIDTH-1:0] active_half
);
  localparam logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_HALF);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q, half_q, pend_q;
  logic             div_q, rise_q, err_q;
  logic             xfer, bad, good, tgl, fall, stop;

  assign cfg.cfg_ready = (state_q != S_PEND);
  assign cfg.cfg_err   = err_q;
  assign div_clk       = div_q;
  assign rise_tick     = rise_q;
  assign active_half   = half_q;

  assign xfer = cfg.cfg_valid && cfg.cfg_ready;
  assign bad  = xfer && (cfg.cfg_half == '0);
  assign good = xfer && !bad;
  assign tgl  = (cnt_q == half_q - WIDTH'(1));
  assign fall = tgl && div_q;
  // A stop waits for the high phase to finish so it is never truncated.
  assign stop = !run && (!div_q || fall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= DEF_HALF;
      pend_q  <= DEF_HALF;
      div_q   <= 1'b0;
      rise_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= bad;
      rise_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          div_q <= 1'b0;
          if (good) half_q  <= cfg.cfg_half;
          if (run)  state_q <= S_RUN;
        end
        default: begin
          if (stop) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            if (state_q == S_PEND) half_q <= pend_q;
            else if (good)         half_q <= cfg.cfg_half;
          end else begin
            if (tgl) begin
              cnt_q  <= '0;
              div_q  <= ~div_q;
              rise_q <= ~div_q;
            end else begin
              cnt_q <= cnt_q + WIDTH'(1);
            end
            // New ratio only takes effect at a falling edge, starting a fresh low phase.
            if (state_q == S_PEND && fall) begin
              half_q  <= pend_q;
              state_q <= S_RUN;
            end
            if (good) begin
              pend_q  <= cfg.cfg_half;
              state_q <= S_PEND;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl: phase-level reference model plus hand-computed timings.
module tb_div_ratio_ctrl;
  localparam int W   = 16;
  localparam int DEF = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic         div_clk, rise_tick;
  logic [W-1:0] active_half;

  div_ratio_ctrl_if #(.WIDTH(W)) cfg_if ();

  div_ratio_ctrl #(.WIDTH(W), .DEFAULT_HALF(DEF)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .cfg        (cfg_if),
    .div_clk    (div_clk),
    .rise_tick  (rise_tick),
    .active_half(active_half)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: tracks the output level, time spent in the current phase,
  // the half-period in force and a queue of not-yet-applied ratios.
  bit m_on, m_lvl, m_rise, m_err;
  int m_el, m_half;
  int m_pend[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_on = 0; m_lvl = 0; m_el = 0; m_half = DEF;
      m_pend.delete(); m_err = 0; m_rise = 0; chk_en = 1;
    end else begin
      bit rdy, xf, bd, gd, ends;
      int h;
      rdy = (m_pend.size() == 0);
      h   = int'(cfg_if.cfg_half);
      xf  = cfg_if.cfg_valid && rdy;
      bd  = xf && (h == 0);
      gd  = xf && !bd;
      m_err  = bd;
      m_rise = 0;
      if (!m_on) begin
        if (gd) m_half = h;
        if (run) begin m_on = 1; m_lvl = 0; m_el = 0; end
      end else begin
        ends = (m_el + 1 == m_half);
        if (!run && (!m_lvl || ends)) begin
          m_on = 0; m_lvl = 0; m_el = 0;
          if (m_pend.size() > 0) m_half = m_pend.pop_front();
          else if (gd)           m_half = h;
        end else begin
          if (ends) begin
            if (!m_lvl) m_rise = 1;
            else if (m_pend.size() > 0) m_half = m_pend.pop_front();
            m_lvl = !m_lvl;
            m_el  = 0;
          end else begin
            m_el++;
          end
          if (gd) m_pend.push_back(h);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("div_clk",     int'(div_clk),          int'(m_lvl));
      chk("rise_tick",   int'(rise_tick),        int'(m_rise));
      chk("cfg_err",     int'(cfg_if.cfg_err),   int'(m_err));
      chk("cfg_ready",   int'(cfg_if.cfg_ready), int'(m_pend.size() == 0));
      chk("active_half", int'(active_half),      m_half);
    end
  end

  task automatic step();
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic send(input int h);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = W'(h);
  endtask

  // Negedges until rise_tick is seen; the request line is dropped after the first.
  task automatic wait_rise(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (rise_tick) return;
    end
    chk("rise_timeout", 0, 1);
    n = -1;
  endtask

  initial begin
    int n, hi;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_half  = '0;
    repeat (3) step();
    chk("rst_half",  int'(active_half), 4);
    chk("rst_ready", int'(cfg_if.cfg_ready), 1);
    chk("rst_div",   int'(div_clk), 0);

    // Default ratio: first rise after 4 RUN cycles, period 8
    rst = 1'b0; run = 1'b1;
    wait_rise(n); chk("first_rise", n, 5);
    wait_rise(n); chk("period_def", n, 8);

    // Zero half-period is rejected with a single-cycle error
    send(0); step();
    chk("err_hi", int'(cfg_if.cfg_err), 1);
    step();
    chk("err_lo", int'(cfg_if.cfg_err), 0);
    wait_rise(n); chk("period_after_err", n, 6);
    wait_rise(n); chk("period_still8", n, 8);

    // Mid-high-phase change to 2 waits for the falling edge
    send(2); step();
    chk("pend_ready", int'(cfg_if.cfg_ready), 0);
    wait_rise(n); chk("pend_first", n, 5);
    chk("half_two", int'(active_half), 2);
    wait_rise(n); chk("period4", n, 4);

    // Switch to 3, then stop during the high phase: it runs to completion
    send(3);
    wait_rise(n); chk("to3_rise", n, 5);
    run = 1'b0; hi = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (div_clk) hi++; else break;
    end
    chk("stop_high_len", hi, 3);
    chk("half_three", int'(active_half), 3);
    step(); step();
    // Stop during the low phase: idle on the next cycle
    run = 1'b1;
    repeat (3) step();
    run = 1'b0;
    step(); step();

    // Config and run together from idle take effect from the first phase
    run = 1'b1; send(5);
    wait_rise(n); chk("idle_cfg_rise", n, 6);
    wait_rise(n); chk("period10", n, 10);

    // Request landing on a falling toggle is deferred to the next one
    repeat (4) step();
    send(2);
    wait_rise(n); chk("coinc_rise", n, 6);
    wait_rise(n); chk("coinc_period", n, 7);

    // Reset while a change is pending discards it
    send(7); step();
    chk("pend7_ready", int'(cfg_if.cfg_ready), 0);
    rst = 1'b1; step();
    chk("rst_pend_half",  int'(active_half), 4);
    chk("rst_pend_ready", int'(cfg_if.cfg_ready), 1);
    chk("rst_pend_div",   int'(div_clk), 0);
    rst = 1'b0;
    wait_rise(n); chk("post_rst_rise", n, 5);
    wait_rise(n); chk("post_rst_period", n, 8);

    run = 1'b0;
    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div_ratio_ctrl.md
DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the half-period count, cfg_half and active_half.
REQ-002 SHALL have parameter DEFAULT_HALF, default 4: half-period loaded at reset; legal range 1..2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1: system clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port run, input, 1: level enable for divided-clock generation.
REQ-006 SHALL have port cfg_valid, input, 1: requester offers a new half-period.
REQ-007 SHALL have port cfg_half, input, WIDTH: requested half-period in clk cycles.
REQ-008 SHALL have port cfg_ready, output, 1: block can accept a cfg.
REQ-009 SHALL have port cfg_err, output, 1: one-cycle pulse; last accepted cfg was rejected.
REQ-010 SHALL have port div_clk, output, 1: divided clock, registered.
REQ-011 SHALL have port rise_tick, output, 1: one-cycle pulse, high in the first cycle div_clk is 1.
REQ-012 SHALL have port active_half, output, WIDTH: half-period currently in effect.

Function
REQ-013 SHALL implement states IDLE, RUN and PEND.
REQ-014 Internal counter: count increments each RUN/PEND cycle; when count==active_half-1, toggle div_clk and clear count; output period = 2*active_half cycles, 50% duty.
REQ-015 In IDLE: div_clk=0, count=0; run=1 -> RUN next cycle, count starts at 0, div_clk low phase first.
REQ-016 Handshake: transfer occurs on cycle with cfg_valid=1 and cfg_ready=1; cfg_ready = 1 in IDLE and RUN, 0 in PEND.
REQ-017 Transfer with cfg_half==0: rejected; cfg_err=1 the next cycle only; no state, count or active_half change.
REQ-018 Legal transfer in IDLE: active_half <= cfg_half next cycle; if run=1 that same cycle, enter RUN using the new value from the first phase.
REQ-019 Legal transfer in RUN: store in pending register, go to PEND; active_half unchanged.
REQ-020 PEND: on the falling toggle (count==active_half-1, div_clk=1), active_half <= pending, count <= 0, state -> RUN; no other cycle changes active_half.
REQ-021 Transfer coinciding with a falling toggle in RUN: applied at the next falling toggle, not the current one.
REQ-022 run=0 in RUN/PEND with div_clk=0: IDLE next cycle, count=0; a pending value is applied to active_half on that transition.
REQ-023 run=0 in RUN/PEND with div_clk=1: continue counting until the falling toggle, then IDLE; pending applied there; run reasserted before that toggle cancels the stop.
REQ-024 rise_tick: registered with the 0->1 toggle of div_clk; never high in IDLE.
REQ-025 div_clk SHALL never produce a high or low phase shorter than min(old, new) active_half cycles.

Reset
REQ-026 rst=1 at a clk edge: state IDLE, div_clk=0, count=0, active_half=DEFAULT_HALF, pending=DEFAULT_HALF, cfg_ready=1, cfg_err=0, rise_tick=0; rst dominates run and cfg_valid.
REQ-027 rst mid-PEND SHALL discard the pending value.

Verification
REQ-028 Reset, run=1 held, no cfg -> div_clk rises after 4 RUN cycles, period 8, rise_tick pulses once every 8 cycles.
REQ-029 In RUN with half=4, cfg_half=2 accepted mid-high-phase -> cfg_ready low until the falling toggle, then active_half=2, period 4.
REQ-030 cfg_valid=1, cfg_half=0 in RUN -> cfg_err high exactly 1 cycle, period stays 8, state stays RUN.
REQ-031 run dropped while div_clk=1 with half=3 -> div_clk completes its 3-cycle high phase, then 0 and IDLE; run dropped while div_clk=0 -> IDLE next cycle.
REQ-032 IDLE, run=1 and cfg_half=5 transferred same cycle -> first high phase begins 5 cycles into RUN, period 10.
REQ-033 rst asserted during PEND -> active_half=4 next cycle, pending value never applied, cfg_ready=1.
